// File: rtl/demux_8_sched.sv
// Purpose : schedules a valid/ready word stream across the 8 outputs of a 1:8 demux
//           (round-robin with skip of not-ready channels, or a fixed configured channel).
// Latency : a word accepted at edge N is presented from edge N; earliest delivery at edge N+1.
// Backpr. : single holding register; in_ready only when empty or the held word delivers this
//           cycle, giving 1 word/cycle with no bubble when the target sink is ready.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   mode, cfg_ch          - 0 = round-robin, 1 = fixed channel cfg_ch (sampled at accept)
//   in_valid/in_data/in_ready - upstream word handshake
//   ch_ready[7:0]         - per-channel sink ready
//   sel, out_data, out_valid - demux select, held word, one-hot channel valid
//   busy, deliv_cnt       - holding register occupied, completed delivery count
module demux_8_sched #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [2:0]       cfg_ch,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    input  logic [7:0]       ch_ready,
    output logic [2:0]       sel,
    output logic [W-1:0]     out_data,
    output logic [7:0]       out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] deliv_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [W-1:0]       data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ptr_q, ptr_d;
    // Mode the held word was accepted under; decides whether its delivery moves ptr.
    logic               held_mode_q, held_mode_d;

    logic               deliver;
    logic               accept;
    logic [2:0]         target;
    logic               found;
    logic [2:0]         idx;

    assign deliver = (state_q == HOLD) && ch_ready[sel_q];
    assign in_ready = (state_q == EMPTY) || deliver;
    assign accept = in_valid && in_ready;

    // Pointer after any same-cycle delivery; the round-robin search for the
    // incoming word starts from this updated value.
    always_comb begin
        ptr_d = ptr_q;
        if (deliver && !held_mode_q) begin
            ptr_d = sel_q + 3'd1;
        end
    end

    // Target selection: first ready channel in cyclic order from ptr_d,
    // falling back to ptr_d itself when nothing is ready.
    always_comb begin
        target = ptr_d;
        found  = 1'b0;
        idx    = 3'd0;
        if (mode) begin
            target = cfg_ch;
        end else begin
            for (int i = 0; i < 8; i++) begin
                idx = ptr_d + 3'(i);
                if (!found && ch_ready[idx]) begin
                    target = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        data_d      = data_q;
        held_mode_d = held_mode_q;
        cnt_d       = cnt_q;
        if (deliver) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = EMPTY;
        end
        // A same-cycle accept overrides the EMPTY transition: the new word
        // replaces the delivered one.
        if (accept) begin
            state_d     = HOLD;
            sel_d       = target;
            data_d      = in_data;
            held_mode_d = mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            sel_q       <= 3'd0;
            data_q      <= '0;
            held_mode_q <= 1'b0;
            cnt_q       <= '0;
            ptr_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            held_mode_q <= held_mode_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = (state_q == HOLD) ? (8'b1 << sel_q) : 8'h00;
    assign busy      = (state_q == HOLD);
    assign deliv_cnt = cnt_q;

endmodule

// File: tb/tb_demux_8_sched.sv
// Purpose : directed self-checking bench for demux_8_sched.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after.
// Backpr. : bench drives ch_ready patterns directly to exercise stall and skip.
module tb_demux_8_sched;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [2:0]       cfg_ch;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [7:0]       ch_ready;
    logic [2:0]       sel;
    logic [W-1:0]     out_data;
    logic [7:0]       out_valid;
    logic             busy;
    logic [CNT_W-1:0] deliv_cnt;

    int n_checks;
    int n_fail;

    demux_8_sched #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .cfg_ch    (cfg_ch),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ch_ready  (ch_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .deliv_cnt (deliv_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mode     = 1'b0;
        cfg_ch   = 3'd0;
        in_valid = 1'b0;
        in_data  = '0;
        ch_ready = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 8'h00 || busy !== 1'b0 || sel !== 3'd0 || out_data !== 8'h00 || deliv_cnt !== 16'd0) begin
            $display("FAIL reset_state: out_valid=%h busy=%b sel=%0d out_data=%h cnt=%0d expected 00/0/0/00/0",
                     out_valid, busy, sel, out_data, deliv_cnt);
            n_fail++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            n_fail++;
        end
    endtask

    task automatic test_round_robin_stream();
        logic [7:0] exp_v;
        test_reset();
        mode     = 1'b0;
        ch_ready = 8'hFF;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 8'h10 + 8'(k);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL rr_in_ready[%0d]: got %b expected 1", k, in_ready);
                n_fail++;
            end
            tick();
            exp_v = 8'b1 << k;
            n_checks++;
            if (sel !== 3'(k) || out_data !== (8'h10 + 8'(k)) || out_valid !== exp_v) begin
                $display("FAIL rr_word[%0d]: sel=%0d data=%h valid=%h expected sel=%0d data=%h valid=%h",
                         k, sel, out_data, out_valid, k, 8'h10 + 8'(k), exp_v);
                n_fail++;
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (deliv_cnt !== 16'd8 || busy !== 1'b0) begin
            $display("FAIL rr_count: cnt=%0d busy=%b expected 8/0", deliv_cnt, busy);
            n_fail++;
        end
        in_valid = 1'b1;
        in_data  = 8'h18;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (sel !== 3'd0 || out_valid !== 8'h01) begin
            $display("FAIL rr_ptr_wrap: sel=%0d valid=%h expected 0/01", sel, out_valid);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_rr_skip();
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'd2;
        exp_sel[1] = 3'd5;
        exp_sel[2] = 3'd2;
        test_reset();
        mode     = 1'b0;
        ch_ready = 8'b0010_0100;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'h20 + 8'(k);
            tick();
            n_checks++;
            if (sel !== exp_sel[k] || out_data !== (8'h20 + 8'(k))) begin
                $display("FAIL skip_target[%0d]: sel=%0d data=%h expected %0d/%h",
                         k, sel, out_data, exp_sel[k], 8'h20 + 8'(k));
                n_fail++;
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (deliv_cnt !== 16'd3 || busy !== 1'b0) begin
            $display("FAIL skip_count: cnt=%0d busy=%b expected 3/0", deliv_cnt, busy);
            n_fail++;
        end
    endtask

    task automatic test_stall();
        test_reset();
        mode     = 1'b1;
        cfg_ch   = 3'd6;
        ch_ready = 8'h00;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) cfg_ch = 3'd3;
            #1;
            n_checks++;
            if (out_valid !== 8'h40 || out_data !== 8'hA5 || in_ready !== 1'b0 || sel !== 3'd6) begin
                $display("FAIL stall_hold[%0d]: valid=%h data=%h in_ready=%b sel=%0d expected 40/a5/0/6",
                         c, out_valid, out_data, in_ready, sel);
                n_fail++;
            end
            tick();
        end
        ch_ready = 8'h40;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL stall_release_ready: got %b expected 1", in_ready);
            n_fail++;
        end
        tick();
        n_checks++;
        if (deliv_cnt !== 16'd1 || out_valid !== 8'h00 || busy !== 1'b0 || sel !== 3'd6) begin
            $display("FAIL stall_deliver: cnt=%0d valid=%h busy=%b sel=%0d expected 1/00/0/6",
                     deliv_cnt, out_valid, busy, sel);
            n_fail++;
        end
    endtask

    task automatic test_rr_no_ready();
        test_reset();
        mode     = 1'b0;
        ch_ready = 8'h04;
        in_valid = 1'b1;
        in_data  = 8'h31;
        tick();
        in_valid = 1'b0;
        tick();
        ch_ready = 8'h00;
        in_valid = 1'b1;
        in_data  = 8'h32;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (sel !== 3'd3 || out_valid !== 8'h08) begin
            $display("FAIL noready_target: sel=%0d valid=%h expected 3/08", sel, out_valid);
            n_fail++;
        end
        ch_ready = 8'h01;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || deliv_cnt !== 16'd1) begin
            $display("FAIL noready_wrong_ch: busy=%b cnt=%0d expected 1/1", busy, deliv_cnt);
            n_fail++;
        end
        ch_ready = 8'h08;
        tick();
        n_checks++;
        if (busy !== 1'b0 || deliv_cnt !== 16'd2) begin
            $display("FAIL noready_deliver: busy=%b cnt=%0d expected 0/2", busy, deliv_cnt);
            n_fail++;
        end
        ch_ready = 8'hFF;
        in_valid = 1'b1;
        in_data  = 8'h33;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (sel !== 3'd4) begin
            $display("FAIL noready_ptr: sel=%0d expected 4", sel);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_async_reset();
        mode     = 1'b1;
        cfg_ch   = 3'd4;
        ch_ready = 8'h00;
        in_valid = 1'b1;
        in_data  = 8'h44;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 8'h10 || deliv_cnt !== 16'd3) begin
            $display("FAIL areset_setup: valid=%h cnt=%0d expected 10/3", out_valid, deliv_cnt);
            n_fail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 8'h00 || busy !== 1'b0 || sel !== 3'd0 || deliv_cnt !== 16'd0 || out_data !== 8'h00) begin
            $display("FAIL areset_immediate: valid=%h busy=%b sel=%0d cnt=%0d data=%h expected 00/0/0/0/00",
                     out_valid, busy, sel, deliv_cnt, out_data);
            n_fail++;
        end
        tick();
        rst_n    = 1'b1;
        mode     = 1'b0;
        ch_ready = 8'hFF;
        in_valid = 1'b1;
        in_data  = 8'h45;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (sel !== 3'd0 || out_valid !== 8'h01) begin
            $display("FAIL areset_first_rr: sel=%0d valid=%h expected 0/01", sel, out_valid);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        test_reset();
        mode     = 1'b0;
        ch_ready = 8'hFF;
        in_valid = 1'b1;
        // 65537 accepts back-to-back: 65536 deliveries complete along the way.
        for (int i = 0; i < 65537; i++) begin
            in_data = 8'(i);
            tick();
            if (i == 65536) begin
                n_checks++;
                if (deliv_cnt !== 16'd0 || sel !== 3'd0 || out_data !== 8'h00 || busy !== 1'b1) begin
                    $display("FAIL cnt_wrap: cnt=%0d sel=%0d data=%h busy=%b expected 0/0/00/1",
                             deliv_cnt, sel, out_data, busy);
                    n_fail++;
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (deliv_cnt !== 16'd1 || busy !== 1'b0) begin
            $display("FAIL cnt_after_wrap: cnt=%0d busy=%b expected 1/0", deliv_cnt, busy);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin_stream();
        test_rr_skip();
        test_stall();
        test_rr_no_ready();
        test_async_reset();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
